// File: rtl/mk14_pkg.sv
// Shared MK14 constants used by the memory-mapped peripherals.
package mk14_pkg;
  localparam logic [7:0] PAGE_DISP  = 8'h0D;
  localparam int         NUM_DIGITS = 8;
  localparam int         KEY_ROWS   = 4;
endpackage

// File: rtl/mk14_disp_kbd_key_debounce.sv
// Two-flop synchronizer plus whole-vector stability counter; out follows the
// synchronized input once it has held still for CYCLES consecutive compares.
module key_debounce #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] kdb
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] ks;
  logic [WIDTH-1:0] kprev;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      ks    <= '0;
      kprev <= '0;
      cnt   <= '0;
      kdb   <= '0;
    end else begin
      sync1 <= keys;
      ks    <= sync1;
      // Any bit toggling anywhere in the matrix restarts the whole window.
      if (ks != kprev) begin
        kprev <= ks;
        cnt   <= '0;
      end else if (cnt == CNT_MAX) begin
        kdb <= kprev;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mk14_disp_kbd.sv
// MK14 display/keypad responder on page 0x0Dxx: write-only digit registers,
// debounced keypad row reads, and a free-running blanked display scan.
module mk14_disp_kbd
  import mk14_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ  = 50,
  parameter int SCAN_DIV        = CLOCK_FREQ_MHZ * 1000,
  parameter int BLANK_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ_MHZ * 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_write_data,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  input  logic [31:0] keys,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic        key_any
);

  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [SC_W-1:0] SC_BLANK = SC_W'(BLANK_CYCLES);

  logic [7:0]          seg_reg [NUM_DIGITS];
  logic [SC_W-1:0]     sc;
  logic [2:0]          dp;
  logic [31:0]         kdb;
  logic                hit;
  logic                wr;
  logic [KEY_ROWS-1:0] rows;
  logic                addr_unused;

  // Address bits 7:4 are don't-care so the page mirrors every 16 bytes.
  assign addr_unused = ^mem_addr[7:4];

  assign hit  = (mem_addr[15:8] == PAGE_DISP);
  assign wr   = en & mem_write_en & hit & ~mem_addr[3];
  assign rows = kdb[{mem_addr[2:0], 2'b00} +: KEY_ROWS];

  key_debounce #(
    .WIDTH  (32),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (keys),
    .kdb   (kdb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) seg_reg[i] <= 8'h00;
    end else if (wr) begin
      seg_reg[mem_addr[2:0]] <= mem_write_data;
    end
  end

  // Rows come back active-low in the upper nibble; segments are never readable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= 8'hFF;
      rd_hit  <= 1'b0;
      key_any <= 1'b0;
    end else begin
      key_any <= |kdb;
      if (en) begin
        rd_hit  <= hit;
        rd_data <= (hit && !mem_addr[3]) ? {~rows, 4'hF} : 8'hFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc  <= '0;
      dp  <= 3'd0;
      dig <= 8'h01;
      seg <= 8'h00;
    end else begin
      dig <= 8'b1 << dp;
      // Blank the head of every slot so the old digit cannot ghost onto the new one.
      seg <= (sc < SC_BLANK) ? 8'h00 : seg_reg[dp];
      if (sc == SC_LAST) begin
        sc <= '0;
        dp <= dp + 3'd1;
      end else begin
        sc <= sc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mk14_disp_kbd.sv
// Bench for mk14_disp_kbd: cycle model plus vector table and corner sequences.
module tb_mk14_disp_kbd;

  localparam int SD = 40;
  localparam int BL = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n, en, we;
  logic [15:0] addr;
  logic [7:0]  wd;
  logic [31:0] keys;
  logic [7:0]  rd_data, seg, dig;
  logic        rd_hit, key_any;

  mk14_disp_kbd #(
    .CLOCK_FREQ_MHZ  (1),
    .SCAN_DIV        (SD),
    .BLANK_CYCLES    (BL),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mem_addr       (addr),
    .mem_write_en   (we),
    .mem_write_data (wd),
    .rd_data        (rd_data),
    .rd_hit         (rd_hit),
    .keys           (keys),
    .seg            (seg),
    .dig            (dig),
    .key_any        (key_any)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: display contents, debounced keys, recent key samples.
  logic [7:0]  m_seg [8];
  logic [31:0] m_kdb;
  logic [31:0] khist [$];
  int          t;
  logic [7:0]  e_rd, e_seg, e_dig;
  logic        e_hit, e_any;

  typedef struct {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        hit;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic step();
    logic       h;
    int         p, sc, d, n;
    logic [3:0] nib;
    bit         stable;
    h = (addr[15:8] == 8'h0D);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_seg[i] = 8'h00;
      m_kdb = '0;
      khist.delete();
      t = 0;
      e_rd = 8'hFF; e_hit = 1'b0; e_seg = 8'h00; e_dig = 8'h01; e_any = 1'b0;
    end else begin
      t++;
      p = t - 1;
      sc = p % SD;
      d = (p / SD) % 8;
      e_dig = 8'h01 << d;
      e_seg = (sc < BL) ? 8'h00 : m_seg[d];
      e_any = (m_kdb != 0);
      if (en) begin
        e_hit = h;
        if (h && addr[3] == 1'b0) begin
          nib  = 4'((m_kdb >> (4 * int'(addr[2:0]))) & 32'hF);
          e_rd = {~nib, 4'hF};
        end else begin
          e_rd = 8'hFF;
        end
      end
      if (en && we && h && addr[3] == 1'b0) m_seg[addr[2:0]] = wd;
      // Debounced value follows the raw keys once DB+1 consecutive samples agree.
      n = khist.size();
      if (n >= DB + 2) begin
        stable = 1'b1;
        for (int i = n - 2 - DB; i <= n - 2; i++)
          if (khist[i] != khist[n-2]) stable = 1'b0;
        if (stable) m_kdb = khist[n-2];
      end
      khist.push_back(keys);
      if (khist.size() > DB + 2) void'(khist.pop_front());
    end
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, e_rd);
    chk("rd_hit", rd_hit, e_hit);
    chk("seg", seg, e_seg);
    chk("dig", dig, e_dig);
    chk("key_any", key_any, e_any);
  endtask

  initial begin
    int guard;

    vt[0] = '{1'b1, 1'b1, 16'h0D02, 8'h3F, 8'hFF, 1'b1};
    vt[1] = '{1'b1, 1'b1, 16'h0DF2, 8'h06, 8'hFF, 1'b1};
    vt[2] = '{1'b1, 1'b1, 16'h0D0A, 8'hFF, 8'hFF, 1'b1};
    vt[3] = '{1'b0, 1'b1, 16'h0C00, 8'h5B, 8'hFF, 1'b1};
    vt[4] = '{1'b1, 1'b0, 16'h0C03, 8'h00, 8'hFF, 1'b0};
    vt[5] = '{1'b1, 1'b0, 16'h0D0A, 8'h00, 8'hFF, 1'b1};
    vt[6] = '{1'b1, 1'b0, 16'h1D02, 8'h00, 8'hFF, 1'b0};
    vt[7] = '{1'b1, 1'b1, 16'h0D15, 8'hAA, 8'hFF, 1'b1};

    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = 16'h0000; wd = 8'h00; keys = '0;
    repeat (3) step();
    chk("reset_dig", dig, 8'h01);
    chk("reset_rd", rd_data, 8'hFF);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      en = vt[i].en; we = vt[i].we; addr = vt[i].addr; wd = vt[i].wd;
      step();
      chk("tbl_rd_data", rd_data, vt[i].rd);
      chk("tbl_rd_hit", rd_hit, vt[i].hit);
    end
    en = 1'b1; we = 1'b0; addr = 16'h0D00;

    // Slot 2: blanked head, mirrored write value, then a live overwrite.
    guard = 0;
    while (dig !== 8'h04 && guard < 1000) begin step(); guard++; end
    chk("slot2_reached", guard < 1000, 1'b1);
    for (int i = 0; i < SD; i++) begin
      chk("slot2_dig", dig, 8'h04);
      chk("slot2_seg", seg, (i < BL) ? 8'h00 : ((i >= 22) ? 8'h77 : 8'h06));
      we   = (i == 20);
      addr = (i == 20) ? 16'h0D02 : 16'h0D00;
      wd   = 8'h77;
      step();
    end
    we = 1'b0;

    // Reset in the middle of slot 5, with a write strobe that must be lost.
    guard = 0;
    while (dig !== 8'h20 && guard < 1000) begin step(); guard++; end
    chk("slot5_reached", guard < 1000, 1'b1);
    repeat (12) step();
    chk("slot5_seg", seg, 8'hAA);
    rst_n = 1'b0; we = 1'b1; addr = 16'h0D05; wd = 8'h55;
    step();
    chk("midrst_dig", dig, 8'h01);
    chk("midrst_seg", seg, 8'h00);
    rst_n = 1'b1; we = 1'b0; addr = 16'h0D03;

    // Bouncing press on col 3 row 1, then stable.
    repeat (4) step();
    for (int b = 0; b < 4; b++) begin
      keys[13] = ~b[0];
      repeat (2) step();
    end
    keys[13] = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      step();
      if (n == 10) chk("db_early_rd", rd_data, 8'hFF);
      if (n == 11) chk("db_early_any", key_any, 1'b0);
      if (n == 12) chk("db_rd", rd_data, 8'hDF);
      if (n == 12) chk("db_any", key_any, 1'b1);
    end
    addr = 16'h0C03;
    step();
    chk("other_page_hit", rd_hit, 1'b0);
    chk("other_page_rd", rd_data, 8'hFF);
    addr = 16'h0D03;
    step();
    chk("col3_rd", rd_data, 8'hDF);
    en = 1'b0; we = 1'b1; addr = 16'h0D00; wd = 8'h5B;
    step();
    chk("en0_hold_rd", rd_data, 8'hDF);
    chk("en0_hold_hit", rd_hit, 1'b1);
    en = 1'b1; we = 1'b0; keys = '0;
    repeat (20) step();

    for (int c = 0; c < 2500; c++) begin
      en   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 3) == 0);
      addr = {($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h0D, 8'($urandom())};
      wd   = 8'($urandom());
      if ($urandom_range(0, 11) == 0)
        keys = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
